// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and helpers for the stream demultiplexer
package stream_demux_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Selector width is clog2(n) but never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_demux_outreg.sv
// rtl/stream_demux_outreg.sv - single-entry stream register with push/pop bookkeeping
module stream_demux_outreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             can_push,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // A pop in the same cycle frees the slot, so back-to-back beats never bubble.
  assign can_push = !full || pop;

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered valid/ready demux with packet lock and drop counter
// Optional packet locking: STREAM_DEMUX_PACKET_LOCK_EN
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int  OUTPUT_COUNT   = 3,
  parameter int  DATA_WIDTH     = 8,
  parameter int  COUNT_WIDTH    = 8,
  localparam int SELECTOR_WIDTH = sel_width(OUTPUT_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [SELECTOR_WIDTH-1:0] selector,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_last,
  output logic [OUTPUT_COUNT-1:0]   out_valid,
  input  logic [OUTPUT_COUNT-1:0]   out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_last,
  output logic [COUNT_WIDTH-1:0]    drop_count
);

  localparam int PAYLOAD_WIDTH = SELECTOR_WIDTH + 1 + DATA_WIDTH;
  localparam logic [SELECTOR_WIDTH:0] CHANNELS = OUTPUT_COUNT[SELECTOR_WIDTH:0];

  logic                      full;
  logic                      can_push;
  logic                      pop;
  logic                      push;
  logic                      accept;
  logic                      drop;
  logic                      gate;
  logic                      locked;
  logic                      first_beat;
  logic [SELECTOR_WIDTH-1:0] cur_sel;
  logic [SELECTOR_WIDTH-1:0] sel_q;
  logic [PAYLOAD_WIDTH-1:0]  reg_q;

`ifdef STREAM_DEMUX_PACKET_LOCK_EN
  state_e                    state_q;
  state_e                    state_d;
  logic [SELECTOR_WIDTH-1:0] lock_sel_q;
  logic [SELECTOR_WIDTH-1:0] lock_sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !in_last) begin
          state_d    = ST_LOCKED;
          lock_sel_d = selector;
        end
      end
      ST_LOCKED: begin
        if (accept && in_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign locked     = (state_q == ST_LOCKED);
  assign cur_sel    = locked ? lock_sel_q : selector;
  assign first_beat = !locked;
`else
  // Without locking every beat is routed, gated and counted on its own.
  assign locked     = 1'b0;
  assign cur_sel    = selector;
  assign first_beat = 1'b1;
`endif

  assign drop     = ({1'b0, cur_sel} >= CHANNELS);
  assign gate     = locked || enable;
  assign in_ready = gate && (drop || can_push);
  assign accept   = in_valid && in_ready;
  assign push     = accept && !drop;

  stream_demux_outreg #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data ({cur_sel, in_last, in_data}),
    .full      (full),
    .can_push  (can_push),
    .data      (reg_q)
  );

  assign {sel_q, out_last, out_data} = reg_q;

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < OUTPUT_COUNT; i++) begin
      out_valid[i] = full && (sel_q == SELECTOR_WIDTH'(i));
    end
  end

  assign pop = |(out_valid & out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (accept && drop && first_beat && (drop_count != {COUNT_WIDTH{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule
